free_list: RTL and testbench

N-way circular free list of physical register tags for the R10K rename stage. Dispatch pops up to N tags per cycle from the head to rename destinations. Retire pushes up to N `t_old` tags per cycle (from retiring ROB entries) at the tail. The head pointer is exported for branch checkpointing and can be restored on a mispredict.

---
 rtl/sys_defs.sv | 9 +
 rtl/psel_count.sv | 17 +
 rtl/free_list.sv | 78 +++++++
 tb/tb_free_list.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/sys_defs.sv
// Shared rename-stage definitions: register-file sizes and the physical tag type
// used by the free list, ROB t/t_old fields and map tables.
package sys_defs;
  localparam int ARCH_REGS = 32;
  localparam int PHYS_REGS = 64;
  localparam int PREG_W    = $clog2(PHYS_REGS);

  typedef logic [PREG_W-1:0] PREG_TAG;
endpackage

// File: rtl/psel_count.sv
// Population count of a request vector; used to size the retire free burst.
module psel_count #(
  parameter int N     = 2,
  parameter int CNT_W = $clog2(N + 1)
) (
  input  logic [N-1:0]     i_req,
  output logic [CNT_W-1:0] o_count
);

  always_comb begin
    o_count = '0;
    for (int i = 0; i < N; i++) begin
      o_count = o_count + CNT_W'(i_req[i]);
    end
  end

endmodule

// File: rtl/free_list.sv
// Circular free list of physical register tags: dispatch pops at the head,
// retire pushes t_old tags at the tail, and the head can be rolled back on a mispredict.
module free_list #(
  parameter int ARCH_REGS = sys_defs::ARCH_REGS,
  parameter int PHYS_REGS = sys_defs::PHYS_REGS,
  parameter int DEPTH     = PHYS_REGS - ARCH_REGS,
  parameter int N         = 2,
  parameter int PREG_W    = $clog2(PHYS_REGS),
  parameter int LOG_DEPTH = $clog2(DEPTH),
  parameter int CNT_W     = $clog2(N + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [CNT_W-1:0]       rd_num,
  input  logic [N-1:0]           wr_valid,
  input  logic [N*PREG_W-1:0]    wr_reg,
  input  logic                   restore_en,
  input  logic [LOG_DEPTH:0]     restore_head,
  output logic [N*PREG_W-1:0]    rd_reg,
  output logic [LOG_DEPTH:0]     num_avail,
  output logic [LOG_DEPTH:0]     head_ptr
);

  localparam int PTR_W = LOG_DEPTH + 1;

  logic [PREG_W-1:0] r_entries [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  w_free_cnt;

  psel_count #(.N(N), .CNT_W(CNT_W)) u_psel_count (
    .i_req   (wr_valid),
    .o_count (w_free_cnt)
  );

  // Tail starts one full lap ahead of head: every non-architectural tag is free.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_entries[i] <= PREG_W'(ARCH_REGS + i);
      end
      r_head <= '0;
      r_tail <= PTR_W'(DEPTH);
    end else begin
      for (int k = 0; k < N; k++) begin
        if (wr_valid[k]) begin
          r_entries[LOG_DEPTH'(r_tail + PTR_W'(k))] <= wr_reg[k*PREG_W +: PREG_W];
        end
      end
      r_tail <= r_tail + PTR_W'(w_free_cnt);
      r_head <= restore_en ? restore_head : r_head + PTR_W'(rd_num);
    end
  end

  // Read-out is purely from registered state; a tag freed this cycle is not forwarded.
  always_comb begin
    rd_reg = '0;
    for (int i = 0; i < N; i++) begin
      rd_reg[i*PREG_W +: PREG_W] = r_entries[LOG_DEPTH'(r_head + PTR_W'(i))];
    end
  end

  assign num_avail = r_tail - r_head;
  assign head_ptr  = r_head;

  a_rd_num_max : assert property (@(posedge clock) disable iff (reset)
    int'(rd_num) <= N);
  a_rd_num_avail : assert property (@(posedge clock) disable iff (reset)
    !restore_en |-> (rd_num <= CNT_W'(0) || int'(rd_num) <= int'(num_avail)));
  a_no_overflow : assert property (@(posedge clock) disable iff (reset)
    int'(num_avail) + int'(w_free_cnt) <= DEPTH);
  a_wr_contig : assert property (@(posedge clock) disable iff (reset)
    (wr_valid & N'(wr_valid + N'(1))) == '0);
  a_restore_range : assert property (@(posedge clock) disable iff (reset)
    restore_en |-> (PTR_W'(r_head - restore_head) <=
                    PTR_W'(r_head - (r_tail - PTR_W'(DEPTH)))));

endmodule

// File: tb/tb_free_list.sv
// Randomized and directed bench for free_list: a queue-based model of the list
// contents feeds an expected queue that a monitor drains against the DUT outputs.
module tb_free_list;

  localparam int N      = 2;
  localparam int DEPTH  = 32;
  localparam int PREG_W = 6;
  localparam int PTR_W  = 6;
  localparam int CNT_W  = 2;
  localparam int W      = 2*PTR_W + N + N*PREG_W;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic [CNT_W-1:0]     rd_num = '0;
  logic [N-1:0]         wr_valid = '0;
  logic [N*PREG_W-1:0]  wr_reg = '0;
  logic                 restore_en = 1'b0;
  logic [PTR_W-1:0]     restore_head = '0;
  logic [N*PREG_W-1:0]  rd_reg;
  logic [PTR_W-1:0]     num_avail;
  logic [PTR_W-1:0]     head_ptr;

  free_list dut (
    .clock        (clock),
    .reset        (reset),
    .rd_num       (rd_num),
    .wr_valid     (wr_valid),
    .wr_reg       (wr_reg),
    .restore_en   (restore_en),
    .restore_head (restore_head),
    .rd_reg       (rd_reg),
    .num_avail    (num_avail),
    .head_ptr     (head_ptr)
  );

  always #5 clock = ~clock;

  // Reference model: list contents in order, tags popped since the checkpoint,
  // and tags in flight that retire may free.
  logic [PREG_W-1:0] fl_q[$];
  logic [PREG_W-1:0] ck_q[$];
  logic [PREG_W-1:0] pool_q[$];
  int                head_cnt = 0;
  int                ck_head = 0;
  bit                ck_valid = 0;

  logic [W-1:0] exp_q[$];
  int chk_cnt = 0;
  int pass_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic push_expect();
    logic [N-1:0]      m;
    logic [PREG_W-1:0] r0, r1;
    m  = {fl_q.size() > 1, fl_q.size() > 0};
    r0 = m[0] ? fl_q[0] : '0;
    r1 = m[1] ? fl_q[1] : '0;
    exp_q.push_back({PTR_W'(fl_q.size()), PTR_W'(head_cnt), m, r1, r0});
  endtask

  task automatic model_reset();
    fl_q.delete(); ck_q.delete(); pool_q.delete();
    for (int i = 0; i < DEPTH; i++) fl_q.push_back(PREG_W'(32 + i));
    for (int i = 0; i < 32; i++) pool_q.push_back(PREG_W'(i));
    head_cnt = 0;
    ck_head  = 0;
    ck_valid = 0;
  endtask

  task automatic take_ckpt();
    while (ck_q.size() > 0) pool_q.push_back(ck_q.pop_front());
    ck_head  = head_cnt;
    ck_valid = 1;
  endtask

  task automatic resolve_ckpt();
    while (ck_q.size() > 0) pool_q.push_back(ck_q.pop_front());
    ck_valid = 0;
  endtask

  task automatic pool_remove(input logic [PREG_W-1:0] t);
    for (int i = 0; i < pool_q.size(); i++) begin
      if (pool_q[i] == t) begin
        pool_q.delete(i);
        return;
      end
    end
  endtask

  // One cycle of stimulus; the model is advanced and its expectation queued.
  task automatic step(input bit do_rst, input int rd, input int nf,
                      input logic [PREG_W-1:0] t0, input logic [PREG_W-1:0] t1,
                      input bit do_rest);
    logic [PREG_W-1:0] t;
    @(negedge clock);
    reset        = do_rst;
    rd_num       = CNT_W'(rd);
    wr_valid     = (nf == 0) ? 2'b00 : (nf == 1) ? 2'b01 : 2'b11;
    wr_reg       = {t1, t0};
    restore_en   = do_rest;
    restore_head = PTR_W'(ck_head);
    if (do_rst) begin
      model_reset();
    end else begin
      if (do_rest) begin
        fl_q = {ck_q, fl_q};
        ck_q.delete();
        head_cnt = ck_head;
      end else begin
        for (int i = 0; i < rd; i++) begin
          t = fl_q.pop_front();
          if (ck_valid) ck_q.push_back(t);
          else pool_q.push_back(t);
          head_cnt++;
        end
      end
      if (nf > 0) fl_q.push_back(t0);
      if (nf > 1) fl_q.push_back(t1);
    end
    push_expect();
  endtask

  // Monitor: outputs are registered, so compare just after each active edge.
  always @(posedge clock) begin
    logic [W-1:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("num_avail", int'(num_avail), int'(e[2*PREG_W+N+PTR_W +: PTR_W]));
      check("head_ptr", int'(head_ptr), int'(e[2*PREG_W+N +: PTR_W]));
      if (e[2*PREG_W]) check("rd_reg0", int'(rd_reg[PREG_W-1:0]), int'(e[PREG_W-1:0]));
      if (e[2*PREG_W+1]) check("rd_reg1", int'(rd_reg[2*PREG_W-1:PREG_W]), int'(e[2*PREG_W-1:PREG_W]));
    end
  end

  initial begin
    int r, rd, nf, room, mx, wait_cyc;
    bit rest;
    logic [PREG_W-1:0] t0, t1;

    model_reset();
    step(1, 0, 0, '0, '0, 0);
    step(1, 0, 0, '0, '0, 0);

    // Drain the whole list two at a time.
    for (int c = 0; c < 16; c++) step(0, 2, 0, '0, '0, 0);

    // Frees into an empty list, then simultaneous alloc and free at num_avail=4.
    pool_remove(6'd5); pool_remove(6'd7);
    step(0, 0, 2, 6'd5, 6'd7, 0);
    pool_remove(6'd20); pool_remove(6'd21);
    step(0, 0, 2, 6'd20, 6'd21, 0);
    pool_remove(6'd10); pool_remove(6'd11);
    step(0, 2, 2, 6'd10, 6'd11, 0);
    step(0, 0, 0, '0, '0, 0);

    // Reset in the middle of a free/restore discards them.
    step(1, 2, 2, 6'd12, 6'd13, 1);

    // Checkpoint at head 3, allocate 6, then restore with one free.
    step(0, 2, 0, '0, '0, 0);
    step(0, 1, 0, '0, '0, 0);
    take_ckpt();
    for (int c = 0; c < 3; c++) step(0, 2, 0, '0, '0, 0);
    t0 = pool_q.pop_front();
    step(0, 2, 1, t0, '0, 1);
    step(0, 0, 0, '0, '0, 0);
    resolve_ckpt();

    // Random traffic with checkpoints, restores and resolves; wraps repeatedly.
    for (int c = 0; c < 600; c++) begin
      r = $urandom_range(0, 15);
      if (r == 1) take_ckpt();
      if (r == 2 && ck_valid) resolve_ckpt();
      rest = ck_valid && (r == 0);
      mx = (fl_q.size() < 2) ? fl_q.size() : 2;
      rd = $urandom_range(0, mx);
      room = DEPTH - fl_q.size() - ck_q.size();
      mx = 2;
      if (pool_q.size() < mx) mx = pool_q.size();
      if (room < mx) mx = room;
      nf = $urandom_range(0, mx);
      t0 = '0; t1 = '0;
      if (nf > 0) t0 = pool_q.pop_front();
      if (nf > 1) t1 = pool_q.pop_front();
      step(0, rd, nf, t0, t1, rest);
    end

    @(negedge clock);
    rd_num = '0; wr_valid = '0; restore_en = 1'b0;
    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 20) begin
      @(negedge clock);
      wait_cyc++;
    end
    if (exp_q.size() > 0) begin
      chk_cnt++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
